// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 2;
  localparam int PIPE_DEST_W = 5;
  localparam int PIPE_CNT_W  = 16;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of the stage: valid bit plus ctrl/dest/data register.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DEST_W = PIPE_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Clearing only drops the valid bit; the payload fields keep their contents.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      dest_d  = in_dest;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign dest  = dest_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional stall counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DEST_W = PIPE_DEST_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  pipe_state_t state_q, state_d;

  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic [DEST_W-1:0] main_dest, skid_dest, main_in_dest;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic              in_xfer, out_xfer;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_d   = FULL;
        end else if (out_xfer) begin
          main_clr = 1'b1;
          state_d  = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every handshake; loads are suppressed so held fields stay put.
    if (flush) begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
      state_d   = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    main_in_ctrl = in_ctrl;
    main_in_dest = in_dest;
    main_in_data = in_data;
    if (main_from_skid) begin
      main_in_ctrl = skid_ctrl;
      main_in_dest = skid_dest;
      main_in_data = skid_data;
    end
  end

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEST_W (DEST_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clr     (main_clr),
    .in_ctrl (main_in_ctrl),
    .in_dest (main_in_dest),
    .in_data (main_in_data),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .dest    (main_dest),
    .data    (main_data)
  );

  pipe_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEST_W (DEST_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clr     (skid_clr),
    .in_ctrl (in_ctrl),
    .in_dest (in_dest),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .dest    (skid_dest),
    .data    (skid_data)
  );

  assign out_ctrl = main_valid ? main_ctrl : '0;
  assign out_dest = main_dest;
  assign out_data = main_data;

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed bench for pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 2;
  localparam int DEST_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEST_W (DEST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_dest  (out_dest),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DEST_W-1:0] d;
    logic [DATA_W-1:0] w;
  } ent_t;

  ent_t q[$];
  int   stall_exp = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic [DEST_W-1:0] d,
                       input logic [DATA_W-1:0] w, input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = c;
    in_dest   = d;
    in_data   = w;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
      check("out_dest", 64'(out_dest), 64'(q[0].d));
      check("out_data", 64'(out_data), 64'(q[0].w));
    end else begin
      check("out_ctrl_bubble", 64'(out_ctrl), 64'd0);
    end
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
  endtask

  // One clock: evaluate the handshake rules on the current inputs, advance the model, compare.
  task automatic step();
    bit   ix, ox, fl;
    ent_t e;
    ix = in_valid && (q.size() < 2);
    ox = (q.size() > 0) && out_ready;
    fl = flush;
    e  = '{c: in_ctrl, d: in_dest, w: in_data};
    if ((q.size() > 0) && !out_ready && stall_exp < (2**CNT_W - 1)) stall_exp++;
    @(posedge clk);
    #1;
    if (ox) q.delete(0);
    if (fl) q.delete();
    else if (ix) q.push_back(e);
    check_outputs();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CTRL_W'($urandom), DEST_W'($urandom), $urandom, 1'(i), 1'(i >> 1));
      @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_dest", 64'(out_dest), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    end
    rst = 1'b1;

    drive(1'b1, 2'b01, 5'd5, 32'h1234ABCD, 1'b0, 1'b0);
    step();
    check("first_data", 64'(out_data), 64'h1234ABCD);
    check("first_dest", 64'(out_dest), 64'd5);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b10, DEST_W'(i), DATA_W'(i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Back-pressure for three cycles mid-stream.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 2'b01, DEST_W'(i), DATA_W'(32'h100 + i), !(i >= 2 && i < 5), 1'b0);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    step();

    // Flush while FULL with an input presented.
    drive(1'b1, 2'b11, 5'd1, 32'hAAAA0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b11, 5'd2, 32'hAAAA0002, 1'b0, 1'b0);
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b11, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1);
    step();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // ctrl=11 entry followed by a bubble.
    drive(1'b1, 2'b11, 5'd7, 32'h77, 1'b1, 1'b0);
    step();
    drive(1'b0, 2'b11, 5'd8, 32'h88, 1'b1, 1'b0);
    step();
    check("bubble_ctrl", 64'(out_ctrl), 64'd0);

    // Long stall saturates the counter, which survives a flush.
    drive(1'b1, 2'b01, 5'd9, 32'h99, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
`ifdef PIPE_STAGE_STATS_EN
    check("stall_sat", 64'(stall_cnt), 64'd15);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 7, CTRL_W'($urandom), DEST_W'($urandom), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      step();
    end

    // Asynchronous reset in the middle of a cycle with data held.
    drive(1'b1, 2'b11, 5'd4, 32'h4444, 1'b0, 1'b0);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    stall_exp = 0;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_out_ctrl", 64'(out_ctrl), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 9) < 5, CTRL_W'($urandom), DEST_W'($urandom), $urandom,
            $urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline stage register for the pipelined MIPS datapath, replacing the fixed always-enabled stage registers between IF/ID/EX/MEM/WB. Carries one payload word, a control bundle and a destination register number per instruction, with valid/ready handshaking, a 2-entry skid buffer so back-pressure is registered, and a synchronous flush that inserts bubbles. Bubbles present all-zero control (for example RegWrite=0 and MemToReg=0), so downstream stages never commit them.

## Interface
- DATA_W, 32, payload width (ALU result / read data / PC, concatenated by the instantiating stage as needed)
- CTRL_W, 2, control bundle width (e.g. {MemToReg, RegWrite})
- DEST_W, 5, destination register number width
- CNT_W, 16, stall counter width (used only with PIPE_STAGE_STATS_EN)
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush: discard every held entry
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle
- in_dest  in  DEST_W  destination register
- in_data  in  DATA_W  payload
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; forced to 0 when out_valid=0
- out_dest  out  DEST_W  destination register
- out_data  out  DATA_W  payload
- stall_cnt  out  CNT_W  present only with PIPE_STAGE_STATS_EN

## Operation
- Storage consists of a main entry, which drives the outputs, and a skid entry. Each entry holds {valid, ctrl, dest, data}.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Combinational outputs:
  - in_ready = !skid.valid. This is registered state, so there is no combinational path from out_ready.
  - out_valid = main.valid.
- State machine:
  - EMPTY: main and skid both invalid.
    - Input transfer -> ONE, main loads input.
  - ONE: main valid, skid invalid.
    - Input and output transfer -> ONE, main loads input.
    - Input transfer only -> FULL, skid loads input.
    - Output transfer only -> EMPTY.
    - Neither -> hold.
  - FULL: main and skid both valid; in_ready=0.
    - Output transfer -> ONE, main loads skid and skid becomes invalid.
    - Otherwise -> hold.
- Flush has highest priority.
  - Next state is EMPTY and both valids are cleared, regardless of handshakes.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - An output handshake in the flush cycle still counts as delivered for the downstream stage.
- Held ctrl, dest and data are unchanged by flush. Only the valid bits clear, and out_ctrl reads 0 through the valid gate.
- Ordering is strict FIFO. No entry is ever duplicated or lost except by flush.

## Timing
- Reset (rst=0, asynchronous):
  - State is EMPTY; both valids = 0 and all stored fields = 0.
  - Outputs: out_valid=0, out_ctrl=0, out_dest=0, out_data=0, in_ready=1, stall_cnt=0.
- Latency: an entry accepted at edge N has out_valid=1 after edge N.
- Throughput: 1 entry/cycle while out_ready=1.
- After out_ready deasserts, in_ready drops one cycle later at the earliest: the skid entry absorbs the single extra entry.
- Reset assertion mid-transfer discards all entries immediately, without waiting for a clock edge.
- Release of rst is synchronised externally; the first accept is at the first edge after release.

## Configuration
- PIPE_STAGE_STATS_EN defined:
  - Adds the stall_cnt port.
  - The counter increments on each cycle with out_valid=1 & out_ready=0, and saturates at 2^CNT_W-1.
  - It is cleared by reset only; flush does not clear it.
- PIPE_STAGE_STATS_EN undefined: no port and no counter logic. Handshake behaviour is identical in both builds.

## Structure
- Shared package pipe_pkg:
  - Enum pipe_state_t {EMPTY, ONE, FULL}.
  - Default widths: DATA_W 32, CTRL_W 2, DEST_W 5, CNT_W 16.
- Sub-module pipe_entry, instantiated twice (main, skid):
  - Contents: valid plus ctrl/dest/data register.
  - Ports: load, clear-valid and asynchronous active-low reset.

## Test plan
- Reset with the inputs toggling -> out_valid=0, out_ctrl=0, in_ready=1; after release, in_data=0x1234ABCD and dest=5 accepted at edge N -> out_data=0x1234ABCD and out_dest=5 after edge N.
- Stream 8 entries (data 1..8) with out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready constantly 1.
- Stream with out_ready=0 for 3 cycles mid-stream -> exactly one extra entry accepted (FULL), then in_ready=0; on release, order is preserved with no loss or duplication.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and the flushed-cycle input never appears at the output.
- ctrl=2'b11 entry followed by a bubble cycle (in_valid=0) -> out_ctrl=2'b00 while out_valid=0.
- PIPE_STAGE_STATS_EN with CNT_W=4 and 20 stall cycles -> stall_cnt saturates at 15 and holds through a flush.
